// File: rtl/cpu_mul_pkg.sv
// cpu_mul_pkg: shared types and helpers for the pipelined multiplier.
// Optional high-word support is selected by CPU_MUL_HIGH_EN (see cpu_mul_pipe).
package cpu_mul_pkg;

    localparam int unsigned CPU_MUL_DATA_W = 32;

    typedef enum logic [1:0] {
        CPU_MUL_OP_MUL = 2'd0,
        CPU_MUL_OP_XSS = 2'd1,
        CPU_MUL_OP_XSU = 2'd2,
        CPU_MUL_OP_XUU = 2'd3
    } cpu_mul_op_e;

    // Operand A is sign-extended for signed*signed and signed*unsigned
    function automatic logic op_signed_a(input cpu_mul_op_e op);
        return (op == CPU_MUL_OP_XSS) || (op == CPU_MUL_OP_XSU);
    endfunction

    // Operand B is sign-extended only for signed*signed
    function automatic logic op_signed_b(input cpu_mul_op_e op);
        return (op == CPU_MUL_OP_XSS);
    endfunction

endpackage

// File: rtl/cpu_mul_pp.sv
// cpu_mul_pp: one registered signed W x W partial product with load enable.
module cpu_mul_pp #(
    parameter int unsigned W = 17
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  en_i,
    input  logic signed [W-1:0]   a_i,
    input  logic signed [W-1:0]   b_i,
    output logic signed [2*W-1:0] p_o
);

    logic signed [2*W-1:0] a_x, b_x, p_d, p_q;

    // Widen both operands first so the product is formed at full result width
    always_comb begin
        a_x = {{W{a_i[W-1]}}, a_i};
        b_x = {{W{b_i[W-1]}}, b_i};
        p_d = en_i ? a_x * b_x : p_q;
    end

    // Product register, held while the stage is stalled
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            p_q <= '0;
        end else begin
            p_q <= p_d;
        end
    end

    assign p_o = p_q;

endmodule

// File: rtl/cpu_mul_pipe.sv
// cpu_mul_pipe: 2-stage DATA_W x DATA_W multiplier with valid/ready handshake.
// S1 holds half-width partial products, S2 holds the summed, selected word.
// Define CPU_MUL_HIGH_EN to build the HH product and enable MULXSS/MULXSU/MULXUU;
// otherwise those ops return 0 with out_err set.
module cpu_mul_pipe
    import cpu_mul_pkg::*;
#(
    parameter int unsigned DATA_W = CPU_MUL_DATA_W,
    parameter int unsigned TAG_W  = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_op,
    input  logic [DATA_W-1:0] in_src1,
    input  logic [DATA_W-1:0] in_src2,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic [TAG_W-1:0]  out_tag,
    output logic              out_err
);

    localparam int unsigned H   = DATA_W / 2;
    localparam int unsigned PPW = DATA_W + 2;   // 2*(H+1)
    localparam int unsigned SW  = 2 * DATA_W;

    logic adv1, adv2;

    logic              v1_q, v1_d, v2_q, v2_d;
    cpu_mul_op_e       op1_q, op1_d;
    logic [TAG_W-1:0]  tag1_q, tag1_d, tag2_q, tag2_d;
    logic [DATA_W-1:0] res2_q, res2_d;
    logic              err2_q, err2_d;

    cpu_mul_op_e       op_in;
    logic [DATA_W:0]   a_x, b_x;
    logic signed [H:0] a_lo, a_hi, b_lo, b_hi;

    logic signed [PPW-1:0] ll, lh, hl;
    logic signed [PPW:0]   mid;
    logic signed [SW-1:0]  ll_x, mid_x, sum;
    logic [DATA_W-1:0]     word;

    // Handshake: an empty stage always loads, a full one loads only when drained
    always_comb begin
        adv2     = ~v2_q | out_ready;
        adv1     = ~v1_q | adv2;
        in_ready = adv1;
    end

    // Extend operands to DATA_W+1 bits and split into unsigned low / signed high halves
    always_comb begin
        op_in = cpu_mul_op_e'(in_op);
        a_x   = {op_signed_a(op_in) & in_src1[DATA_W-1], in_src1};
        b_x   = {op_signed_b(op_in) & in_src2[DATA_W-1], in_src2};
        a_lo  = {1'b0, a_x[H-1:0]};
        b_lo  = {1'b0, b_x[H-1:0]};
        a_hi  = a_x[DATA_W:H];
        b_hi  = b_x[DATA_W:H];
    end

    cpu_mul_pp #(.W(H + 1)) u_pp_ll (
        .clk_i (clk), .rst_i (reset), .en_i (adv1), .a_i (a_lo), .b_i (b_lo), .p_o (ll)
    );
    cpu_mul_pp #(.W(H + 1)) u_pp_lh (
        .clk_i (clk), .rst_i (reset), .en_i (adv1), .a_i (a_lo), .b_i (b_hi), .p_o (lh)
    );
    cpu_mul_pp #(.W(H + 1)) u_pp_hl (
        .clk_i (clk), .rst_i (reset), .en_i (adv1), .a_i (a_hi), .b_i (b_lo), .p_o (hl)
    );

`ifdef CPU_MUL_HIGH_EN
    logic signed [PPW-1:0] hh;
    logic signed [SW-1:0]  hh_x;

    cpu_mul_pp #(.W(H + 1)) u_pp_hh (
        .clk_i (clk), .rst_i (reset), .en_i (adv1), .a_i (a_hi), .b_i (b_hi), .p_o (hh)
    );

    // Full product; only the low 2*DATA_W bits can reach the result, so the sum is kept at that width
    always_comb begin
        mid   = {lh[PPW-1], lh} + {hl[PPW-1], hl};
        ll_x  = {{(SW-PPW){ll[PPW-1]}}, ll};
        mid_x = {{(SW-PPW-1){mid[PPW]}}, mid};
        hh_x  = {{(SW-PPW){hh[PPW-1]}}, hh};
        sum   = ll_x + (mid_x << H) + (hh_x << DATA_W);
        word  = (op1_q == CPU_MUL_OP_MUL) ? sum[DATA_W-1:0] : sum[SW-1:DATA_W];
        err2_d = adv2 ? 1'b0 : err2_q;
        res2_d = adv2 ? word : res2_q;
    end
`else
    // Without HH the high word is meaningless; high-word ops are flagged and zeroed
    always_comb begin
        mid   = {lh[PPW-1], lh} + {hl[PPW-1], hl};
        ll_x  = {{(SW-PPW){ll[PPW-1]}}, ll};
        mid_x = {{(SW-PPW-1){mid[PPW]}}, mid};
        sum   = ll_x + (mid_x << H);
        word  = (op1_q == CPU_MUL_OP_MUL) ? sum[DATA_W-1:0] : sum[SW-1:DATA_W];
        err2_d = adv2 ? (op1_q != CPU_MUL_OP_MUL) : err2_q;
        res2_d = adv2 ? ((op1_q == CPU_MUL_OP_MUL) ? word : '0) : res2_q;
    end
`endif

    // Stage control next-state: load on advance, otherwise hold
    always_comb begin
        v1_d   = adv1 ? in_valid : v1_q;
        op1_d  = adv1 ? op_in    : op1_q;
        tag1_d = adv1 ? in_tag   : tag1_q;
        v2_d   = adv2 ? v1_q     : v2_q;
        tag2_d = adv2 ? tag1_q   : tag2_q;
    end

    // Stage registers; reset discards anything in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v1_q   <= 1'b0;
            op1_q  <= CPU_MUL_OP_MUL;
            tag1_q <= '0;
            v2_q   <= 1'b0;
            tag2_q <= '0;
            res2_q <= '0;
            err2_q <= 1'b0;
        end else begin
            v1_q   <= v1_d;
            op1_q  <= op1_d;
            tag1_q <= tag1_d;
            v2_q   <= v2_d;
            tag2_q <= tag2_d;
            res2_q <= res2_d;
            err2_q <= err2_d;
        end
    end

    assign out_valid  = v2_q;
    assign out_result = res2_q;
    assign out_tag    = tag2_q;
    assign out_err    = err2_q;

endmodule

// File: tb/tb_cpu_mul_pipe.sv
// tb_cpu_mul_pipe: directed and randomized checks of cpu_mul_pipe (DATA_W=32),
// against an arithmetic product model; follows CPU_MUL_HIGH_EN like the design.
module tb_cpu_mul_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_op;
    logic [31:0] in_src1, in_src2;
    logic [4:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [4:0]  out_tag;
    logic        out_err;

    cpu_mul_pipe #(.DATA_W(32), .TAG_W(5)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_src1    (in_src1),
        .in_src2    (in_src2),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_tag    (out_tag),
        .out_err    (out_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  tag;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    int unsigned hs_cyc[$];
    logic [4:0]  hs_tag[$];
    int unsigned total = 0;
    int unsigned bad   = 0;
    int unsigned cyc   = 0;

    logic        s_in_ready, s_out_valid, s_out_err, s_acc;
    logic [31:0] s_out_result;
    logic [4:0]  s_out_tag;

    // Result of op on a,b as {err, word}: full 64-bit product of extended operands
    function automatic logic [32:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ax, bx, p;
        ax = (op == 2'd1 || op == 2'd2) ? {{32{a[31]}}, a} : {32'h0, a};
        bx = (op == 2'd1) ? {{32{b[31]}}, b} : {32'h0, b};
        p  = ax * bx;
        if (op == 2'd0) return {1'b0, p[31:0]};
`ifdef CPU_MUL_HIGH_EN
        return {1'b0, p[63:32]};
`else
        return {1'b1, 32'h0};
`endif
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'h0000_0001;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    // One clock: sample handshakes mid-cycle, score outputs, record accepts, advance
    task automatic tick();
        exp_t        e;
        logic [32:0] m;
        #1;
        s_in_ready   = in_ready;
        s_out_valid  = out_valid;
        s_out_result = out_result;
        s_out_tag    = out_tag;
        s_out_err    = out_err;
        s_acc        = in_valid && in_ready;
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("spurious_out", {63'h0, out_valid}, 64'h0);
            end else begin
                e = sb.pop_front();
                check("sb_result", {32'h0, out_result}, {32'h0, e.res});
                check("sb_tag", {59'h0, out_tag}, {59'h0, e.tag});
                check("sb_err", {63'h0, out_err}, {63'h0, e.err});
            end
            hs_cyc.push_back(cyc);
            hs_tag.push_back(out_tag);
        end
        if (s_acc) begin
            m     = model(in_op, in_src1, in_src2);
            e.res = m[31:0];
            e.err = m[32];
            e.tag = in_tag;
            sb.push_back(e);
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    // Single op on an idle pipe: expected word given for the full build
    task automatic single(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] tg, input logic [31:0] exp_full, input string name);
        logic [31:0] er;
        logic        ee;
        er = exp_full;
        ee = 1'b0;
`ifndef CPU_MUL_HIGH_EN
        if (op != 2'd0) begin
            er = 32'h0;
            ee = 1'b1;
        end
`endif
        in_valid = 1'b1; in_op = op; in_src1 = a; in_src2 = b; in_tag = tg; out_ready = 1'b1;
        tick();
        check({name, "_accept"}, {63'h0, s_in_ready}, 64'h1);
        in_valid = 1'b0;
        tick();
        check({name, "_lat1_valid"}, {63'h0, s_out_valid}, 64'h0);
        tick();
        check({name, "_lat2_valid"}, {63'h0, s_out_valid}, 64'h1);
        check({name, "_result"}, {32'h0, s_out_result}, {32'h0, er});
        check({name, "_tag"}, {59'h0, s_out_tag}, {59'h0, tg});
        check({name, "_err"}, {63'h0, s_out_err}, {63'h0, ee});
    endtask

    initial begin
        int unsigned a0, issued;
        logic [32:0] m;
        logic        exp_rdy[4];
        logic        exp_ov[4];

        reset = 1'b1; in_valid = 1'b0; in_op = 2'd0; in_src1 = '0; in_src2 = '0;
        in_tag = '0; out_ready = 1'b0;

        // Reset state
        @(posedge clk); @(negedge clk); @(posedge clk); @(negedge clk);
        check("rst_out_valid", {63'h0, out_valid}, 64'h0);
        check("rst_out_result", {32'h0, out_result}, 64'h0);
        check("rst_out_tag", {59'h0, out_tag}, 64'h0);
        check("rst_out_err", {63'h0, out_err}, 64'h0);
        reset = 1'b0;
        #1;
        check("rst_in_ready", {63'h0, in_ready}, 64'h1);

        // Directed boundary products
        single(2'd0, 32'h0001_0000, 32'h0001_0000, 5'd1, 32'h0000_0000, "p16_mul");
        single(2'd3, 32'h0001_0000, 32'h0001_0000, 5'd2, 32'h0000_0001, "p16_xuu");
        single(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'h0000_0001, "ones_mul");
        single(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 32'h0000_0000, "ones_xss");
        single(2'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5, 32'hFFFF_FFFF, "ones_xsu");
        single(2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, 32'hFFFF_FFFE, "ones_xuu");
        m = model(2'd0, 32'h1234_5678, 32'h9ABC_DEF0);
        single(2'd0, 32'h1234_5678, 32'h9ABC_DEF0, 5'd7, m[31:0], "mix_mul");
        m = model(2'd3, 32'h1234_5678, 32'h9ABC_DEF0);
        single(2'd3, 32'h1234_5678, 32'h9ABC_DEF0, 5'd8, m[31:0], "mix_xuu");

        // Back-to-back burst: 8 consecutive results, in order
        hs_cyc.delete(); hs_tag.delete();
        a0 = cyc;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; in_op = 2'($urandom_range(0, 3));
            in_src1 = pick(); in_src2 = pick(); in_tag = 5'(i);
            tick();
        end
        in_valid = 1'b0;
        for (int c = 0; c < 20 && sb.size() != 0; c++) tick();
        check("burst_count", 64'(hs_tag.size()), 64'd8);
        for (int i = 0; i < 8 && i < hs_tag.size(); i++) begin
            check("burst_tag", {59'h0, hs_tag[i]}, 64'(i));
            check("burst_cycle", 64'(hs_cyc[i]), 64'(a0 + 2 + i));
        end

        // Backpressure: two accepts fill the pipe, then in_ready drops and output holds
        hs_cyc.delete(); hs_tag.delete();
        exp_rdy = '{1'b1, 1'b1, 1'b0, 1'b0};
        exp_ov  = '{1'b0, 1'b0, 1'b1, 1'b1};
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1; in_op = 2'($urandom_range(0, 3));
            in_src1 = pick(); in_src2 = pick(); in_tag = 5'(16 + k);
            tick();
            check("stall_in_ready", {63'h0, s_in_ready}, {63'h0, exp_rdy[k]});
            check("stall_out_valid", {63'h0, s_out_valid}, {63'h0, exp_ov[k]});
            if (k == 3) begin
                check("stall_hold_result", {32'h0, out_result}, {32'h0, s_out_result});
                check("stall_hold_tag", {59'h0, out_tag}, {59'h0, 5'd16});
            end
        end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 20 && sb.size() != 0; c++) tick();
        check("stall_release_count", 64'(hs_tag.size()), 64'd2);
        check("stall_release_empty", 64'(sb.size()), 64'd0);

        // Reset with both stages full
        out_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            in_valid = 1'b1; in_op = 2'd0; in_src1 = pick(); in_src2 = pick(); in_tag = 5'(24 + k);
            tick();
        end
        in_valid = 1'b0;
        tick();
        reset = 1'b1;
        #1;
        check("midrst_out_valid", {63'h0, out_valid}, 64'h0);
        check("midrst_out_result", {32'h0, out_result}, 64'h0);
        check("midrst_out_tag", {59'h0, out_tag}, 64'h0);
        check("midrst_out_err", {63'h0, out_err}, 64'h0);
        @(posedge clk); @(negedge clk);
        reset = 1'b0;
        sb.delete(); hs_cyc.delete(); hs_tag.delete();
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            check("postrst_no_stale", {63'h0, s_out_valid}, 64'h0);
        end
        single(2'd0, 32'd7, 32'd6, 5'd9, 32'd42, "postrst_7x6");

        // Randomized ops with random input gaps and output stalls
        issued = 0;
        for (int c = 0; c < 30000 && issued < 3000; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_op     = 2'($urandom_range(0, 3));
            in_src1   = pick();
            in_src2   = pick();
            in_tag    = 5'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
            if (s_acc) issued++;
        end
        check("rand_issued", 64'(issued), 64'd3000);
        in_valid = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 20 && sb.size() != 0; c++) tick();
        check("rand_drain_empty", 64'(sb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
